// File: rtl/rc_osc_monitor.sv
// Enable sequencer and frequency checker for the 16 MHz RC oscillator macro.
// Counts synchronized oscillator edges over a fixed reference window and qualifies osc_ok.
//
// state   | meaning
// S_OFF   | oscillator disabled, counters held clear
// S_STARTUP | oscillator enabled, waiting for first edges or timeout
// S_MEASURE | first qualification window in progress
// S_RUN   | frequency verified, measuring back-to-back windows
// S_FAULT | oscillator disabled, fault_code latched until clear_fault
module rc_osc_monitor #(
  parameter int CNT_W           = 16,
  parameter int WIN_CYCLES      = 1024,
  parameter int STARTUP_EDGES   = 4,
  parameter int STARTUP_TIMEOUT = 1024,
  parameter int MIN_CNT         = 295,
  parameter int MAX_CNT         = 360
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic             clear_fault,
  input  logic             osc_dout,
  output logic             osc_ena,
  output logic             osc_ok,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] last_count,
  output logic             count_valid
);

  localparam int TMO_W = $clog2(STARTUP_TIMEOUT);
  localparam int WIN_W = $clog2(WIN_CYCLES);
  localparam int SE_W  = $clog2(STARTUP_EDGES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(STARTUP_TIMEOUT - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [SE_W-1:0]  SE_LAST  = SE_W'(STARTUP_EDGES - 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CNT);

  typedef enum logic [2:0] {S_OFF, S_STARTUP, S_MEASURE, S_RUN, S_FAULT} state_t;

  state_t           state, state_nx;
  logic [2:0]       sync_q;
  logic             edge_p;
  logic [TMO_W-1:0] tmo_cnt, tmo_nx;
  logic [SE_W-1:0]  se_cnt, se_nx;
  logic [WIN_W-1:0] win_cnt, win_nx;
  logic [CNT_W-1:0] edge_cnt, edge_nx, edge_sum, lc_nx;
  logic [1:0]       code_nx;
  logic             cv_nx;

  // Two synchronizer flops, a history flop and a registered edge pulse: 3-cycle latency
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      edge_p <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], osc_dout};
      edge_p <= sync_q[1] & ~sync_q[2];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_OFF;
      tmo_cnt     <= '0;
      se_cnt      <= '0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
      fault_code  <= 2'b00;
      last_count  <= '0;
      count_valid <= 1'b0;
      osc_ena     <= 1'b0;
      osc_ok      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      tmo_cnt     <= tmo_nx;
      se_cnt      <= se_nx;
      win_cnt     <= win_nx;
      edge_cnt    <= edge_nx;
      fault_code  <= code_nx;
      last_count  <= lc_nx;
      count_valid <= cv_nx;
      osc_ena     <= (state_nx == S_STARTUP) || (state_nx == S_MEASURE) || (state_nx == S_RUN);
      osc_ok      <= (state_nx == S_RUN);
      fault       <= (state_nx == S_FAULT);
    end
  end

  // Saturating sum includes an edge landing in the final window cycle
  assign edge_sum = (edge_cnt == '1) ? edge_cnt : edge_cnt + CNT_W'(edge_p);

  always_comb begin
    state_nx = state;
    tmo_nx   = tmo_cnt;
    se_nx    = se_cnt;
    win_nx   = win_cnt;
    edge_nx  = edge_cnt;
    code_nx  = fault_code;
    lc_nx    = last_count;
    cv_nx    = 1'b0;
    case (state)
      S_OFF: begin
        tmo_nx  = '0;
        se_nx   = '0;
        win_nx  = '0;
        edge_nx = '0;
        if (en) state_nx = S_STARTUP;
      end
      S_STARTUP: begin
        if (!en) begin
          state_nx = S_OFF;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
          if (edge_p) se_nx = se_cnt + 1'b1;
          if (edge_p && (se_cnt == SE_LAST)) begin
            state_nx = S_MEASURE;
            tmo_nx   = '0;
            se_nx    = '0;
            win_nx   = '0;
            edge_nx  = '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state_nx = S_FAULT;
            code_nx  = 2'b01;
          end
        end
      end
      S_MEASURE, S_RUN: begin
        if (!en) begin
          state_nx = S_OFF;
        end else begin
          edge_nx = edge_sum;
          win_nx  = win_cnt + 1'b1;
          if (win_cnt == WIN_LAST) begin
            win_nx  = '0;
            edge_nx = '0;
            lc_nx   = edge_sum;
            cv_nx   = 1'b1;
            if (edge_sum < CNT_MIN) begin
              state_nx = S_FAULT;
              code_nx  = 2'b10;
            end else if (edge_sum > CNT_MAX) begin
              state_nx = S_FAULT;
              code_nx  = 2'b11;
            end else begin
              state_nx = S_RUN;
            end
          end
        end
      end
      S_FAULT: begin
        tmo_nx  = '0;
        se_nx   = '0;
        win_nx  = '0;
        edge_nx = '0;
        if (clear_fault) begin
          code_nx  = 2'b00;
          state_nx = en ? S_STARTUP : S_OFF;
        end
      end
      default: state_nx = S_OFF;
    endcase
  end

endmodule
